// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the decoder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a. Optional feature macro used by instr_fetch: IFETCH_PERF_CNT_EN.
package instr_fetch_pkg;

  // Fetch unit state: FETCH owns the memory request, HOLD owns the decoder handoff.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Program counter value after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Primary opcodes (instru[31:26]) of the control-transfer instructions.
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // True for the opcodes whose redirect outcome the fetch unit consumes.
  function automatic logic is_ctrl_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Sign-extended, word-scaled branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next_calc.sv
// Next-PC selection for an accepted instruction: jump, taken branch or sequential.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples next_pc only on the accept cycle.
module pc_next_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_out,
  input  logic [31:0] instru,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Bne,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic        ctrl_op_unused;

  // All additions are 32-bit and simply wrap modulo 2^32.
  assign pc4           = pc_out + 32'd4;
  assign jump_target   = {pc4[31:28], instru[25:0], 2'b00};
  assign branch_target = pc4 + branch_offset(instru[15:0]);
  assign branch_taken  = Branch && (Zero ^ Bne);

  // The decoder already classified the opcode; this keeps the field visible here.
  assign ctrl_op_unused = is_ctrl_op(instru[31:26]);

  // Jump has priority over a branch asserted in the same cycle.
  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, instruction held for the decoder.
// Latency: 1 cycle from imem_ack to instr_valid; imem_req re-rises 1 cycle after accept.
// Backpressure: instru/pc_out held while id_ready is low; no new fetch until accept.
// Build option IFETCH_PERF_CNT_EN adds the fetch_count accept counter port.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instru,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic [31:0] pc_out,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Bne,
  input  logic        Zero
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         accept;
  logic         fetch_done;

  // Handshakes: an ack only counts while a request is outstanding.
  assign accept     = (state == HOLD) && instr_valid && id_ready;
  assign fetch_done = (state == FETCH) && imem_req && imem_ack;

  // PC is word aligned by construction (reset value and all increments are multiples of 4).
  assign imem_addr = pc;

  pc_next_calc u_pc_next_calc (
    .pc_out  (pc_out),
    .instru  (instru),
    .Jump    (Jump),
    .Branch  (Branch),
    .Bne     (Bne),
    .Zero    (Zero),
    .next_pc (next_pc)
  );

  // FETCH/HOLD controller with registered memory and decoder-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instru      <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // Only reached straight out of reset: start the first fetch.
            imem_req <= 1'b1;
          end else if (fetch_done) begin
            instru      <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Count accepted instructions; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'h0000_0000;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  // Accept counter not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an address/instruction scoreboard.
// Latency: checks 1-cycle fetch latency and request re-issue after accept.
// Backpressure: exercises imem wait states and decoder stalls.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instru;
  logic        instr_valid;
  logic        id_ready;
  logic [31:0] pc_out;
  logic        Jump, Branch, Bne, Zero;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int errors = 0;
  int checks = 0;
  int accepts = 0;

  logic [31:0] addr_q[$];
  logic [31:0] ins_q[$];
  logic [31:0] pc_q[$];

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instru      (instru),
    .instr_valid (instr_valid),
    .id_ready    (id_ready),
    .pc_out      (pc_out),
    .Jump        (Jump),
    .Branch      (Branch),
    .Bne         (Bne),
    .Zero        (Zero)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference next-PC model, written from the architectural definition.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic j, input logic b,
                                             input logic bne_i, input logic z);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    if (b && (z != bne_i)) return p4 + 32'($signed(ins[15:0])) * 32'd4;
    return p4;
  endfunction

  // Wait for a request, check its address against the scoreboard, insert wait states, ack.
  task automatic do_fetch(input logic [31:0] data, input int waits);
    logic [31:0] ea;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    if (addr_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_addr_empty observed=0 expected=1");
      ea = 32'h0;
    end else begin
      ea = addr_q.pop_front();
    end
    check("imem_addr", imem_addr, ea);
    for (int i = 0; i < waits; i++) begin
      // Decoder-side noise while nothing is valid must be ignored.
      id_ready   = 1'b1;
      Jump       = 1'b1;
      Branch     = 1'b1;
      imem_rdata = $urandom;
      tick();
      check("addr_stable", imem_addr, ea);
      check("req_held", 32'(imem_req), 32'd1);
      check("valid_low_fetch", 32'(instr_valid), 32'd0);
    end
    id_ready   = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    ins_q.push_back(data);
    pc_q.push_back(ea);
  endtask

  // Check the held instruction, optionally stall, then accept with the given redirects.
  task automatic do_accept(input logic j, input logic b, input logic bne_i, input logic z,
                           input int stall);
    logic [31:0] ei, ep;
    ei = ins_q.pop_front();
    ep = pc_q.pop_front();
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instru", instru, ei);
    check("pc_out", pc_out, ep);
    for (int i = 0; i < stall; i++) begin
      id_ready = 1'b0;
      Jump     = 1'($urandom);
      Branch   = 1'($urandom);
      Zero     = 1'($urandom);
      tick();
      check("stall_instru", instru, ei);
      check("stall_pc_out", pc_out, ep);
      check("stall_no_req", 32'(imem_req), 32'd0);
    end
    addr_q.push_back(model_next(ep, ei, j, b, bne_i, z));
    id_ready = 1'b1;
    Jump     = j;
    Branch   = b;
    Bne      = bne_i;
    Zero     = z;
    tick();
    id_ready = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    Bne      = 1'b0;
    Zero     = 1'b0;
    accepts++;
    check("valid_drop", 32'(instr_valid), 32'd0);
    check("req_after_accept", 32'(imem_req), 32'd1);
  endtask

  initial begin
    // Reset with a stray ack and decoder noise present.
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    id_ready   = 1'b1;
    Jump       = 1'b1;
    Branch     = 1'b1;
    Bne        = 1'b0;
    Zero       = 1'b1;
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instru", instru, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);

    // First edge after release raises the request; the ack seen there is ignored.
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    id_ready = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    Zero     = 1'b0;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", 32'(instr_valid), 32'd0);
    addr_q.push_back(32'h0);

    // Sequential run 0x0, 0x4, 0x8.
    do_fetch(32'h2401_0011, 0);
    do_accept(0, 0, 0, 0, 0);
    check("seq_addr_4", imem_addr, 32'h4);
    do_fetch(32'h2402_0022, 0);
    do_accept(0, 0, 0, 0, 0);
    check("seq_addr_8", imem_addr, 32'h8);
    do_fetch(32'h2403_0033, 0);
    do_accept(0, 0, 0, 0, 0);
    do_fetch(32'h0000_0000, 1);
    do_accept(0, 0, 0, 0, 0);
    check("seq_addr_10", imem_addr, 32'h10);

    // beq at 0x10, imm -2: taken -> 0x0C, not taken -> 0x14.
    do_fetch({OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 0);
    do_accept(0, 1, 0, 1, 0);
    check("beq_taken", imem_addr, 32'h0000_000C);
    do_fetch(32'h0000_0020, 0);
    do_accept(0, 0, 0, 0, 0);
    do_fetch({OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 0);
    do_accept(0, 1, 0, 0, 0);
    check("beq_not_taken", imem_addr, 32'h0000_0014);

    // Jump to 0x20, then bne imm 3 -> 0x30.
    do_fetch({OP_J, 26'h000_0008}, 0);
    do_accept(1, 0, 0, 0, 0);
    check("jump_0x20", imem_addr, 32'h0000_0020);
    do_fetch({OP_BNE, 5'd3, 5'd4, 16'h0003}, 0);
    do_accept(0, 1, 1, 0, 0);
    check("bne_taken", imem_addr, 32'h0000_0030);

    // Negative branch wrapping below zero, then sequential wrap to 0 with a decoder stall.
    do_fetch({OP_BEQ, 5'd0, 5'd0, 16'hFFF2}, 0);
    do_accept(0, 1, 0, 1, 0);
    check("branch_wrap", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0040, 0);
    do_accept(0, 0, 0, 0, 4);
    check("seq_wrap", imem_addr, 32'h0000_0000);

    // Jump and branch together at 0xFFFF_FFF8: jump wins, upper nibble from pc4.
    do_fetch({OP_BEQ, 5'd0, 5'd0, 16'hFFFD}, 0);
    do_accept(0, 1, 0, 1, 0);
    check("branch_back", imem_addr, 32'hFFFF_FFF8);
    do_fetch({OP_J, 26'h000_0040}, 0);
    do_accept(1, 1, 0, 1, 0);
    check("jump_priority", imem_addr, 32'hF000_0100);

    // Three memory wait states.
    do_fetch(32'h1234_5678, 3);
    do_accept(0, 0, 0, 0, 0);

    // Reset pulse during an outstanding fetch; ack arrives right after release.
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_pc_out", pc_out, 32'h0);
    addr_q.delete();
    ins_q.delete();
    pc_q.delete();
    accepts    = 0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    rst_n      = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("late_ack_addr", imem_addr, 32'h0);
    addr_q.push_back(32'h0);
    do_fetch(32'hCAFE_0001, 2);
    do_accept(0, 0, 0, 0, 0);
    check("post_rst_next", imem_addr, 32'h4);

`ifdef IFETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'(accepts));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request, held until imem_ack.
REQ-005 imem_addr  output  32  word-aligned fetch address (current PC); bits [1:0] always 0.
REQ-006 imem_ack  input  1  read data valid this cycle; ignored when imem_req is low.
REQ-007 imem_rdata  input  32  instruction word, sampled when imem_req and imem_ack are both high.
REQ-008 instru  output  32  held instruction presented to the decoder.
REQ-009 instr_valid  output  1  instru is valid.
REQ-010 id_ready  input  1  decoder accepts instru this cycle.
REQ-011 pc_out  output  32  address of the instruction on instru.
REQ-012 Jump, Branch, Bne, Zero  input  1 each  decoder/ALU outcome for the instruction on instru; sampled only on the accept cycle.

Function
REQ-013 States: FETCH (imem_req=1), HOLD (instr_valid=1), with one fetch outstanding at most.
REQ-014 FETCH to HOLD on imem_ack: capture imem_rdata into instru, PC into pc_out. instr_valid rises the next cycle. A same-cycle ack gives 1-cycle fetch latency.
REQ-015 HOLD to FETCH on accept (instr_valid && id_ready). The next PC is computed from the sampled redirect inputs, and imem_req rises the following cycle.
REQ-016 Next PC priority on accept:
- Jump=1: {pc4[31:28], instru[25:0], 2'b00}.
- else Branch=1 and (Zero XOR Bne)=1: pc4 + (sext(instru[15:0]) << 2).
- else pc4.
- Here pc4 = pc_out + 4.
REQ-017 Jump and Branch asserted together: Jump wins.
REQ-018 All PC arithmetic is modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0x0000_0000, and negative branch offsets wrap likewise.
REQ-019 id_ready while instr_valid=0 is ignored, and redirect inputs outside the accept cycle are ignored.
REQ-020 In FETCH, imem_addr is stable until ack, and imem_rdata without imem_req is ignored.
REQ-021 instru, pc_out and instr_valid are stable in HOLD until accept.

Reset
REQ-022 While rst_n=0, the block SHALL hold: state=FETCH, PC=0x0000_0000, imem_req=0, instru=0x0000_0000, pc_out=0, instr_valid=0.
REQ-023 On the first clock edge after rst_n deasserts, the block SHALL raise imem_req with imem_addr=0.
REQ-024 Reset asserted mid-fetch or mid-hold SHALL discard the outstanding request and any held instruction, and a late imem_ack SHALL be ignored.

Configuration
REQ-025 Macro IFETCH_PERF_CNT_EN:
- Defined: adds output fetch_count [31:0], reset to 0, incremented on each accept, wrapping at 2^32.
- Undefined: the port and counter are absent.
- All other behaviour is identical in both builds.

Structure
REQ-026 The shared package SHALL hold:
- the state enum (FETCH, HOLD);
- the reset PC constant (0x0000_0000);
- the opcode constants for j, beq and bne shared with the decoder.
REQ-027 One sub-module, pc_next_calc, SHALL be purely combinational. Inputs: pc_out, instru, Jump, Branch, Bne, Zero. Output: next PC.

Verification
REQ-028 Sequential run: reset, then imem_ack every cycle after 0 waits, id_ready=1, no redirects -> imem_addr sequence 0x0, 0x4, 0x8, with each instru matching the memory words.
REQ-029 Taken beq: pc_out=0x10, instru imm=0xFFFE, Branch=1, Zero=1, Bne=0 on accept -> next imem_addr=0x0C. Same with Zero=0 -> 0x14.
REQ-030 bne plus jump priority:
- Bne=1, Zero=0, imm=0x0003, pc_out=0x20 -> next imem_addr=0x30.
- Jump=1 with Branch=1, instru[25:0]=0x0000040, pc_out=0x3000_0000 -> next imem_addr=0x3000_0100.
REQ-031 Backpressure plus wait states:
- imem_ack delayed 3 cycles -> imem_addr stable throughout.
- id_ready low 4 cycles -> instru and pc_out unchanged, no new imem_req.
REQ-032 Boundaries:
- pc_out=0xFFFF_FFFC, sequential accept -> next imem_addr=0x0.
- rst_n pulsed low during FETCH with imem_ack arriving after release -> instr_valid stays 0 until the fresh fetch from address 0 completes.
